// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width codes, register map, control/status bit
// positions and the serial bit ordering helpers used by spis and spie.
package spi_pkg;

    typedef enum logic [1:0] {
        WIDTH_8     = 2'b00,
        WIDTH_32    = 2'b01,
        WIDTH_16    = 2'b10,
        WIDTH_8_ALT = 2'b11
    } width_e;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int CTRL_WIDTH_LSB = 4;
    localparam int CTRL_MSB_FIRST = 6;
    localparam int CTRL_CLR_OVR   = 7;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_OVERRUN  = 3;

    function automatic logic [4:0] last_bit(input width_e w);
        case (w)
            WIDTH_32: return 5'd31;
            WIDTH_16: return 5'd15;
            default:  return 5'd7;
        endcase
    endfunction

    // Word bit carried by serial bit number cnt: bits MSB-first within a byte,
    // bytes LS-first unless msb_first reverses the byte order.
    function automatic logic [4:0] bit_pos(input width_e w, input logic msb_first,
                                           input logic [4:0] cnt);
        logic [4:0] lb;
        logic [1:0] byte_idx;
        lb       = last_bit(w);
        byte_idx = cnt[4:3];
        if (msb_first) byte_idx = lb[4:3] - byte_idx;
        return {byte_idx, ~cnt[2:0]};
    endfunction

endpackage

// File: rtl/spis_rxtx.sv
// Serial side of the SPI target: cs_n/sclk/mosi synchronisers, edge detection,
// bit counter and the tx/rx word registers.
module spis_rxtx import spi_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    input  width_e      width,
    input  logic        msb_first,
    input  logic [31:0] tx_word,
    input  logic        tx_full,
    output logic        miso,
    output logic        miso_en,
    output logic        busy,
    output logic        tx_load,
    output logic        rx_done,
    output logic [31:0] rx_word
);
    logic        cs_meta_q, cs_sync_q, cs_prev_q;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d, active_q, active_d;
    logic        miso_q, miso_d, msb_q, msb_d;
    width_e      width_q, width_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, load_word;
    logic        cs_fall, sclk_rise, sclk_fall;

    // NOTE: every flop is written with <= so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {cs_meta_q, cs_sync_q, cs_prev_q}       <= 3'b111;
            {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= 3'b000;
            {mosi_meta_q, mosi_sync_q}              <= 2'b00;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
            msb_q    <= 1'b0;
            width_q  <= WIDTH_8;
            cnt_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
        end else begin
            {cs_meta_q, cs_sync_q, cs_prev_q}       <= {cs_n, cs_meta_q, cs_sync_q};
            {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= {sclk, sclk_meta_q, sclk_sync_q};
            {mosi_meta_q, mosi_sync_q}              <= {mosi, mosi_meta_q};
            fill_q   <= fill_d;
            armed_q  <= armed_d;
            active_q <= active_d;
            miso_q   <= miso_d;
            msb_q    <= msb_d;
            width_q  <= width_d;
            cnt_q    <= cnt_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
        end
    end

    // A frame may only start after cs_n has been seen high with a refilled
    // synchroniser, so a reset in mid-frame never fakes a falling edge.
    assign cs_fall   = armed_q & cs_prev_q & ~cs_sync_q;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign load_word = tx_full ? tx_word : '0;

    // NOTE: all outputs of this block get a default first, so no latches are inferred.
    always_comb begin
        fill_d   = {fill_q[0], 1'b1};
        armed_d  = armed_q | (fill_q[1] & cs_sync_q);
        active_d = active_q;
        miso_d   = miso_q;
        msb_d    = msb_q;
        width_d  = width_q;
        cnt_d    = cnt_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        tx_load  = 1'b0;
        rx_done  = 1'b0;
        rx_word  = rx_sh_q;
        rx_word[bit_pos(width_q, msb_q, cnt_q)] = mosi_sync_q;

        if (cs_fall) begin
            active_d = 1'b1;
            width_d  = width;
            msb_d    = msb_first;
            cnt_d    = '0;
            tx_sh_d  = load_word;
            rx_sh_d  = '0;
            miso_d   = load_word[bit_pos(width, msb_first, 5'd0)];
            tx_load  = 1'b1;
        end else if (active_q) begin
            if (cs_sync_q) begin
                active_d = 1'b0;
                cnt_d    = '0;
                rx_sh_d  = '0;
                miso_d   = 1'b0;
            end else if (sclk_rise) begin
                if (cnt_q == last_bit(width_q)) begin
                    rx_done = 1'b1;
                    cnt_d   = '0;
                    tx_sh_d = load_word;
                    rx_sh_d = '0;
                    tx_load = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    rx_sh_d = rx_word;
                end
            end else if (sclk_fall) begin
                miso_d = tx_sh_q[bit_pos(width_q, msb_q, cnt_q)];
            end
        end
    end

    assign miso    = miso_q;
    assign miso_en = active_q & ~cs_sync_q;
    assign busy    = ~cs_sync_q;

endmodule

// File: rtl/spis.sv
// SPI target with a two-register bus interface (data, control/status).
// Optional registered interrupt output enabled by defining SPIS_IRQ_EN.
module spis (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_en
`ifdef SPIS_IRQ_EN
    ,
    output logic        irq
`endif
);
    import spi_pkg::*;

    logic [31:0] rx_buf_q, rx_buf_d, tx_buf_q, tx_buf_d, rx_word, status;
    logic        rx_full_q, rx_full_d, tx_full_q, tx_full_d, overrun_q, overrun_d;
    logic        msb_q, msb_d;
    width_e      width_q, width_d;
    logic        busy, tx_load, rx_done;
    logic        data_rd, data_wr, stat_rd, ctrl_wr;

    spis_rxtx u_rxtx (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .width     (width_q),
        .msb_first (msb_q),
        .tx_word   (tx_buf_q),
        .tx_full   (tx_full_q),
        .miso      (miso),
        .miso_en   (miso_en),
        .busy      (busy),
        .tx_load   (tx_load),
        .rx_done   (rx_done),
        .rx_word   (rx_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf_q  <= '0;
            tx_buf_q  <= '0;
            rx_full_q <= 1'b0;
            tx_full_q <= 1'b0;
            overrun_q <= 1'b0;
            msb_q     <= 1'b0;
            width_q   <= WIDTH_8;
        end else begin
            rx_buf_q  <= rx_buf_d;
            tx_buf_q  <= tx_buf_d;
            rx_full_q <= rx_full_d;
            tx_full_q <= tx_full_d;
            overrun_q <= overrun_d;
            msb_q     <= msb_d;
            width_q   <= width_d;
        end
    end

    assign ack     = stb;
    assign data_rd = stb & ~we & (addr == ADDR_DATA);
    assign data_wr = stb &  we & (addr == ADDR_DATA);
    assign stat_rd = stb & ~we & (addr == ADDR_CTRL);
    assign ctrl_wr = stb &  we & (addr == ADDR_CTRL);

    always_comb begin
        status                = '0;
        status[STAT_BUSY]     = busy;
        status[STAT_RX_FULL]  = rx_full_q;
        status[STAT_TX_EMPTY] = ~tx_full_q;
        status[STAT_OVERRUN]  = overrun_q;

        data_out = '0;
        if (data_rd)      data_out = rx_buf_q;
        else if (stat_rd) data_out = status;
    end

    always_comb begin
        rx_buf_d  = rx_buf_q;
        tx_buf_d  = tx_buf_q;
        rx_full_d = rx_full_q;
        tx_full_d = tx_full_q;
        overrun_d = overrun_q;
        msb_d     = msb_q;
        width_d   = width_q;

        if (ctrl_wr) begin
            width_d = width_e'(data_in[CTRL_WIDTH_LSB +: 2]);
            msb_d   = data_in[CTRL_MSB_FIRST];
            if (data_in[CTRL_CLR_OVR]) overrun_d = 1'b0;
        end

        // The shifter already took the old tx_buf this cycle, so a write wins the flag.
        if (data_wr) begin
            tx_buf_d  = data_in;
            tx_full_d = 1'b1;
        end else if (tx_load) begin
            tx_full_d = 1'b0;
        end

        // A read in the completion cycle frees the buffer for the new word.
        if (rx_done) begin
            if (!rx_full_q || data_rd) begin
                rx_buf_d  = rx_word;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_rd) begin
            rx_full_d = 1'b0;
        end
    end

`ifdef SPIS_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= rx_full_d | overrun_d;
    end

    assign irq = irq_q;
`endif

endmodule
